// File: rtl/timed_event_dispatcher_pkg.sv
// Shared types and constants for the timed event dispatcher.
package rtio_pkg;

   localparam int unsigned EVT_TS_WIDTH   = 64;
   localparam int unsigned EVT_DATA_WIDTH = 32;

   // One buffered event at the default widths.
   typedef struct packed {
      logic [EVT_TS_WIDTH-1:0]   ts;
      logic [EVT_DATA_WIDTH-1:0] data;
   } event_t;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      FIRE
   } dispatcher_state_t;

   // Late-drop counter increment that sticks at all-ones.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/timed_event_dispatcher_if.sv
// Host-side event input and downstream event output handshakes.
interface timed_event_dispatcher_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TS_WIDTH   = 64
);

   logic                  in_valid;
   logic                  in_ready;
   logic [TS_WIDTH-1:0]   in_timestamp;
   logic [DATA_WIDTH-1:0] in_data;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [TS_WIDTH-1:0]   out_timestamp;

   modport master (
      output in_valid, in_timestamp, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_timestamp
   );

   modport slave (
      input  in_valid, in_timestamp, in_data, out_ready,
      output in_ready, out_valid, out_data, out_timestamp
   );

endinterface

// File: rtl/timed_event_dispatcher_sync_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers and a combinational read port.
module sync_fifo #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o = wr_ptr_q - rd_ptr_q;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // A push into a full FIFO is allowed only when the head leaves the same cycle.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   // Pointer advance; flush discards contents and any same-cycle write.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write port.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i && !reset) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/timed_event_dispatcher.sv
// Buffers timestamped events and releases each when the timestamp counter
// reaches it; events whose time has already passed are dropped and counted.
module timed_event_dispatcher
   import rtio_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = EVT_DATA_WIDTH,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned TS_WIDTH   = EVT_TS_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [TS_WIDTH-1:0]      counter,
   timed_event_dispatcher_if.slave  bus,
   input  logic                     flush,
   input  logic                     clear_error,
   output logic                     late_error,
   output logic [15:0]              late_count,
   output logic [$clog2(DEPTH):0]   fill_level
);

   localparam int unsigned EW = TS_WIDTH + DATA_WIDTH;

   typedef struct packed {
      logic [TS_WIDTH-1:0]   ts;
      logic [DATA_WIDTH-1:0] data;
   } evt_t;

   dispatcher_state_t state_q, state_d;
   evt_t              head_q, head_d;
   logic              late_error_q, late_error_d;
   logic [15:0]       late_count_q, late_count_d;

   logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [EW-1:0]     fifo_wdata, fifo_rdata_raw;
   evt_t              fifo_rdata;

   assign bus.in_ready  = !fifo_full && !reset;
   assign fifo_push     = bus.in_valid && bus.in_ready;
   assign fifo_wdata    = {bus.in_timestamp, bus.in_data};
   assign fifo_rdata    = evt_t'(fifo_rdata_raw);

   // The head register doubles as the output holding register while in FIRE.
   assign bus.out_valid     = (state_q == FIRE);
   assign bus.out_data      = head_q.data;
   assign bus.out_timestamp = head_q.ts;
   assign late_error        = late_error_q;
   assign late_count        = late_count_q;

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata_raw),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fill_level)
   );

   // Next-state, head load and late bookkeeping.
   always_comb begin
      state_d      = state_q;
      head_d       = head_q;
      fifo_pop     = 1'b0;
      late_error_d = late_error_q;
      late_count_d = late_count_q;

      // Clear is applied first so a same-cycle late drop still leaves a count of one.
      if (clear_error) begin
         late_error_d = 1'b0;
         late_count_d = '0;
      end

      if (flush) begin
         state_d = IDLE;
         head_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  head_d   = fifo_rdata;
                  state_d  = ARMED;
               end
            end
            ARMED: begin
               if (head_q.ts == counter) begin
                  state_d = FIRE;
               end else if (head_q.ts < counter) begin
                  state_d      = IDLE;
                  late_error_d = 1'b1;
                  late_count_d = sat_inc16(late_count_d);
               end
            end
            FIRE: begin
               if (bus.out_ready) begin
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     head_d   = fifo_rdata;
                     state_d  = ARMED;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, head and error registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         head_q       <= '0;
         late_error_q <= 1'b0;
         late_count_q <= '0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         late_error_q <= late_error_d;
         late_count_q <= late_count_d;
      end
   end

endmodule

// File: tb/tb_timed_event_dispatcher.sv
// Directed scenarios followed by a randomized run checked against a
// timeline model of event load, compare, fire and acceptance cycles.
module tb_timed_event_dispatcher;
   import rtio_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned NEV   = 12;
   localparam int          NCYC  = 1000;
   localparam longint unsigned CB = 64'd10000;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] counter;
   logic        flush, clear_error;
   logic        late_error;
   logic [15:0] late_count;
   logic [$clog2(DEPTH):0] fill_level;
   logic        run;

   int total = 0;
   int bad   = 0;

   timed_event_dispatcher_if #(.DATA_WIDTH(32), .TS_WIDTH(64)) bus ();

   timed_event_dispatcher #(
      .DATA_WIDTH (32),
      .DEPTH      (DEPTH),
      .TS_WIDTH   (64)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .counter     (counter),
      .bus         (bus),
      .flush       (flush),
      .clear_error (clear_error),
      .late_error  (late_error),
      .late_count  (late_count),
      .fill_level  (fill_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs and counter change 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (run) counter = counter + 64'd1;
   endtask

   task automatic write1(input logic [63:0] ts, input logic [31:0] d);
      bus.in_valid     = 1'b1;
      bus.in_timestamp = ts;
      bus.in_data      = d;
      tick();
      bus.in_valid     = 1'b0;
   endtask

   // Reference-model storage for the randomized run.
   event_t      evs [NEV];
   int          wcyc [NEV];
   bit          rdy [1100];
   int          exp_k [$];
   int          exp_x [$];
   int          s, lc, f, x, idle_at, acc_at, lates, kw, k, nwr, got, nv;
   logic [63:0] seen_cnt [3];
   bit          seen, sawv, acc;

   initial begin
      reset = 1'b1; run = 1'b0; counter = '0; flush = 1'b0; clear_error = 1'b0;
      bus.in_valid = 1'b0; bus.in_timestamp = '0; bus.in_data = '0; bus.out_ready = 1'b0;

      // Reset values
      tick(); tick();
      chk("rst_in_ready", bus.in_ready, 0);
      reset = 1'b0;
      tick();
      chk("rst_in_ready_after", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_ts", bus.out_timestamp, 0);
      chk("rst_late_error", late_error, 0);
      chk("rst_late_count", late_count, 0);
      chk("rst_fill", fill_level, 0);

      // Single event written at counter=10, fires after the counter passes 100
      counter = 0; run = 1'b1; bus.out_ready = 1'b1;
      for (int i = 0; i < 50 && counter != 64'd10; i++) tick();
      write1(64'd100, 32'hA5A5);
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         tick();
         if (bus.out_valid) seen = 1;
      end
      chk("single_seen", seen, 1);
      chk("single_rise_counter", counter, 101);
      chk("single_out_ts", bus.out_timestamp, 100);
      chk("single_out_data", bus.out_data, 32'hA5A5);
      chk("single_no_late", late_error, 0);
      tick();
      chk("single_valid_drop", bus.out_valid, 0);

      // Late event and clear_error
      counter = 500;
      write1(64'd400, 32'h1);
      sawv = 0;
      repeat (5) begin tick(); sawv |= bus.out_valid; end
      chk("late_no_valid", sawv, 0);
      chk("late_error", late_error, 1);
      chk("late_count", late_count, 1);
      clear_error = 1'b1; tick(); clear_error = 1'b0;
      chk("clear_late_error", late_error, 0);
      chk("clear_late_count", late_count, 0);

      // Backpressure: ts=50 held, 51/52 go late while stalled
      bus.out_ready = 1'b0; counter = 40;
      write1(64'd50, 32'h50); write1(64'd51, 32'h51); write1(64'd52, 32'h52);
      for (int i = 0; i < 40 && counter != 64'd60; i++) tick();
      chk("bp_valid_held", bus.out_valid, 1);
      chk("bp_ts_held", bus.out_timestamp, 50);
      chk("bp_fill", fill_level, 2);
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
      sawv = 0;
      repeat (8) begin sawv |= bus.out_valid; tick(); end
      chk("bp_no_more_valid", sawv, 0);
      chk("bp_late_count", late_count, 2);
      clear_error = 1'b1; tick(); clear_error = 1'b0;

      // No backpressure: three events fire with one idle cycle between them
      bus.out_ready = 1'b1; counter = 40;
      write1(64'd50, 32'h50); write1(64'd52, 32'h52); write1(64'd54, 32'h54);
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.out_valid && nv < 3) begin seen_cnt[nv] = counter; nv++; end
      end
      chk("b2b_count", nv, 3);
      chk("b2b_first", seen_cnt[0], 51);
      chk("b2b_second", seen_cnt[1], 53);
      chk("b2b_third", seen_cnt[2], 55);
      chk("b2b_no_late", late_count, 0);

      // Full FIFO with frozen counter; the stalled write must survive
      run = 1'b0; counter = 0; bus.out_ready = 1'b0; nwr = 0;
      for (int i = 0; i < int'(DEPTH) + 2; i++) begin
         bus.in_valid = 1'b1;
         bus.in_timestamp = 64'd1000 + 64'(2 * i);
         bus.in_data = 32'(i);
         acc = 0;
         for (int c = 0; c < 4 && !acc; c++) begin acc = bus.in_ready; tick(); end
         if (!acc) break;
         nwr++;
      end
      chk("full_writes", nwr, DEPTH + 1);
      chk("full_fill", fill_level, DEPTH);
      chk("full_in_ready", bus.in_ready, 0);
      chk("full_no_valid", bus.out_valid, 0);
      counter = 1000; run = 1'b1; bus.out_ready = 1'b1; got = 0;
      for (int c = 0; c < 300 && got < int'(DEPTH) + 2; c++) begin
         acc = bus.in_valid && bus.in_ready;
         if (bus.out_valid) begin
            chk("full_drain_data", bus.out_data, got);
            chk("full_drain_ts", bus.out_timestamp, 64'd1000 + 64'(2 * got));
            got++;
         end
         tick();
         if (acc) bus.in_valid = 1'b0;
      end
      chk("full_drain_count", got, DEPTH + 2);
      chk("full_drain_late", late_count, 0);

      // Flush with one event in FIRE and four queued; error state kept
      run = 1'b0; counter = 3000; bus.out_ready = 1'b0;
      write1(64'd2999, 32'h99);
      repeat (4) tick();
      write1(64'd3000, 32'h30);
      for (int i = 0; i < 4; i++) write1(64'd4000 + 64'(i), 32'(i));
      tick(); tick();
      chk("flush_pre_valid", bus.out_valid, 1);
      chk("flush_pre_fill", fill_level, 4);
      flush = 1'b1; bus.in_valid = 1'b1; bus.in_timestamp = 64'd5000; bus.in_data = 32'h55;
      tick();
      flush = 1'b0; bus.in_valid = 1'b0;
      chk("flush_valid", bus.out_valid, 0);
      chk("flush_fill", fill_level, 0);
      chk("flush_late_error", late_error, 1);
      chk("flush_late_count", late_count, 1);
      repeat (3) tick();
      chk("flush_write_discarded", fill_level, 0);
      chk("flush_still_idle", bus.out_valid, 0);

      // Reset in the middle of activity
      write1(64'd9000, 32'h9); write1(64'd9001, 32'hA);
      tick();
      reset = 1'b1; #1;
      chk("midrst_in_ready", bus.in_ready, 0);
      tick();
      reset = 1'b0;
      chk("midrst_fill", fill_level, 0);
      chk("midrst_out_data", bus.out_data, 0);
      chk("midrst_out_ts", bus.out_timestamp, 0);
      chk("midrst_late_error", late_error, 0);
      chk("midrst_late_count", late_count, 0);

      // Forward counter jump past an armed event
      counter = 200; run = 1'b1; bus.out_ready = 1'b1;
      write1(64'd1000, 32'h10);
      repeat (3) tick();
      counter = 5000;
      sawv = 0;
      repeat (3) begin tick(); sawv |= bus.out_valid; end
      chk("jump_fwd_no_valid", sawv, 0);
      chk("jump_fwd_late", late_count, 1);

      // clear_error coinciding with a late drop: the drop wins
      counter = 200;
      write1(64'd100, 32'h11);
      tick();
      clear_error = 1'b1; tick(); clear_error = 1'b0;
      chk("clr_drop_error", late_error, 1);
      chk("clr_drop_count", late_count, 1);
      clear_error = 1'b1; tick(); clear_error = 1'b0;

      // Backward counter jump: the armed event waits and fires on time
      counter = 200;
      write1(64'd1000, 32'h12);
      repeat (3) tick();
      counter = 900;
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         tick();
         if (bus.out_valid) seen = 1;
      end
      chk("jump_back_seen", seen, 1);
      chk("jump_back_counter", counter, 1001);
      chk("jump_back_ts", bus.out_timestamp, 1000);
      chk("jump_back_no_late", late_count, 0);

      // Randomized run: build stimulus, derive expected timeline, then drive
      lc = 0;
      for (int i = 0; i < int'(NEV); i++) begin
         lc += int'($urandom_range(6, 1));
         wcyc[i] = lc;
         evs[i].ts = CB + 64'(lc) + 64'($urandom_range(34, 0)) - 64'd4;
         evs[i].data = $urandom;
      end
      for (int t = 0; t < 1100; t++) rdy[t] = (t >= 700) ? 1'b1 : 1'($urandom_range(1, 0));

      idle_at = 0; acc_at = -1; lates = 0;
      for (k = 0; k < int'(NEV); k++) begin
         // First cycle in which this event's timestamp is compared
         if (acc_at >= 0 && wcyc[k] < acc_at) s = acc_at + 1;
         else begin
            lc = (idle_at > wcyc[k] + 1) ? idle_at : wcyc[k] + 1;
            s = lc + 1;
         end
         if (evs[k].ts < CB + 64'(s)) begin
            lates++;
            idle_at = s + 1;
            acc_at = -1;
         end else begin
            f = s + int'(evs[k].ts - (CB + 64'(s)));
            x = f + 1;
            while (x < 1099 && !rdy[x]) x++;
            exp_k.push_back(k);
            exp_x.push_back(x);
            acc_at = x;
            idle_at = x + 1;
         end
      end

      reset = 1'b1; run = 1'b0; bus.in_valid = 1'b0;
      tick(); tick();
      reset = 1'b0; counter = CB; run = 1'b1; kw = 0;
      for (int t = 0; t < NCYC; t++) begin
         bus.out_ready = rdy[t];
         bus.in_valid = 1'b0;
         if (kw < int'(NEV) && wcyc[kw] == t) begin
            bus.in_valid = 1'b1;
            bus.in_timestamp = evs[kw].ts;
            bus.in_data = evs[kw].data;
            chk("rand_in_ready", bus.in_ready, 1);
            kw++;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_k.size() == 0) begin
               chk("rand_unexpected_out", bus.out_timestamp, 0);
            end else begin
               k = exp_k.pop_front();
               x = exp_x.pop_front();
               chk("rand_out_cycle", t, x);
               chk("rand_out_ts", bus.out_timestamp, evs[k].ts);
               chk("rand_out_data", bus.out_data, evs[k].data);
            end
         end
         tick();
      end
      chk("rand_missing_outputs", exp_k.size(), 0);
      chk("rand_late_count", late_count, lates);
      chk("rand_late_error", late_error, (lates != 0));
      chk("rand_final_fill", fill_level, 0);
      chk("rand_final_valid", bus.out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
